// File: rtl/bus_select_encoder.sv
// One-hot bus-source strobe to registered 5-bit mux select, with conflict detection.
// Optional saturating conflict counter enabled by defining BUS_SELECT_ENCODER_CONFLICT_CNT_EN.
module bus_select_encoder (
    input  logic        clock,
    input  logic        clear,
    input  logic [24:0] out_req,
    input  logic        err_clr,
    output logic [4:0]  S,
    output logic        valid,
    output logic        conflict,
    output logic        conflict_sticky,
    output logic [7:0]  conflict_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    logic [0:0] state_q, state_d;
    logic [4:0] s_q, s_d;
    logic       conflict_q, conflict_d;
    logic       sticky_q, sticky_d;
    logic       req_any;
    logic       req_multi;
    logic [4:0] enc;

    // Scanning downward lets the lowest set bit overwrite, giving bit 0 top priority.
    always_comb begin
        enc       = 5'd0;
        req_any   = |out_req;
        req_multi = |(out_req & (out_req - 25'd1));
        for (int i = 24; i >= 0; i--) begin
            if (out_req[i]) begin
                enc = 5'(i);
            end
        end

        state_d    = req_any ? DRIVE : IDLE;
        s_d        = req_any ? enc : s_q;
        conflict_d = req_multi;
        sticky_d   = req_multi | (sticky_q & ~err_clr);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            s_q        <= 5'd0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef BUS_SELECT_ENCODER_CONFLICT_CNT_EN
    logic [7:0] count_q, count_d;

    // A conflict on the same edge as err_clr restarts the count at one rather than zero.
    always_comb begin
        count_d = count_q;
        if (req_multi) begin
            if (err_clr) begin
                count_d = 8'd1;
            end else if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end else if (err_clr) begin
            count_d = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign conflict_count = count_q;
`else
    assign conflict_count = 8'd0;
`endif

    assign S               = s_q;
    assign valid           = (state_q == DRIVE);
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;

endmodule

// File: doc/bus_select_encoder.md
BUS_SELECT_ENCODER -- requirements
Module: bus_select_encoder

Interface
REQ-001 The block SHALL have port clock, input, 1 bit, the single rising-edge clock for all state.
REQ-002 The block SHALL have port clear, input, 1 bit, with synchronous active-high reset sampled on the rising edge of clock.
REQ-003 The block SHALL have port out_req, input, 25 bits, one-hot source-drive strobes. Bit i maps to bus select code i: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhi, 19 Zlo, 20 PC, 21 MDR, 22 In_Port, 23 C_sign_extended, 24 Y.
REQ-004 The block SHALL have port err_clr, input, 1 bit, which clears the sticky conflict state.
REQ-005 The block SHALL have port S, output, 5 bits, the registered bus-mux select code.
REQ-006 The block SHALL have port valid, output, 1 bit, high when S reflects a request sampled in the previous cycle.
REQ-007 The block SHALL have port conflict, output, 1 bit, a one-cycle pulse for a multi-hot sample.
REQ-008 The block SHALL have port conflict_sticky, output, 1 bit, set on any conflict and held until cleared.
REQ-009 The block SHALL have port conflict_count, output, 8 bits, the saturating count of conflict cycles.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no source driving) and DRIVE (a source is selected).
REQ-011 IDLE->DRIVE SHALL occur on a clock edge with out_req != 0; DRIVE->IDLE SHALL occur on an edge with out_req == 0; DRIVE->DRIVE SHALL occur with out_req != 0.
REQ-012 S SHALL update one cycle after out_req is sampled nonzero, with a fixed latency of 1 clock.
REQ-013 If out_req is zero, S SHALL hold its previous value and valid SHALL be 0 in the following cycle.
REQ-014 valid SHALL be 1 exactly while the FSM is in DRIVE.
REQ-015 If more than one bit of out_req is set, S SHALL take the lowest set bit index (fixed priority, bit 0 highest).
REQ-016 S SHALL never take a value in 25-31 under any input.
REQ-017 conflict SHALL be 1 for exactly the cycle following a sample with two or more bits of out_req set, and 0 otherwise.
REQ-018 conflict_sticky SHALL set on the same edge that raises conflict.
REQ-019 err_clr SHALL clear conflict_sticky and conflict_count on the next edge.
REQ-020 If err_clr and a new conflict occur on the same edge, the conflict SHALL win: sticky=1 and count=1.
REQ-021 conflict_count SHALL increment by 1 per conflict cycle and saturate at 255 with no wrap.
REQ-022 A conflict SHALL NOT block selection: valid and S SHALL still follow REQ-012 and REQ-015.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-024 On clear=1 at an edge, the FSM SHALL enter IDLE with S=0, valid=0, conflict=0, conflict_sticky=0, and conflict_count=0.
REQ-025 clear SHALL take priority over out_req and err_clr on the same edge.
REQ-026 If clear is asserted mid-DRIVE, it SHALL abort selection and the block SHALL resume normally on the first edge after clear deasserts.

Configuration
REQ-027 Macro BUS_SELECT_ENCODER_CONFLICT_CNT_EN SHALL control the conflict counter.
REQ-028 When BUS_SELECT_ENCODER_CONFLICT_CNT_EN is defined, the block SHALL implement conflict_count per REQ-019 to REQ-021.
REQ-029 When BUS_SELECT_ENCODER_CONFLICT_CNT_EN is undefined, conflict_count SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Bench SHALL cover: clear for 2 cycles, then out_req=0 -> S=0, valid=0, conflict=0, sticky=0, count=0.
REQ-031 Bench SHALL cover: out_req=1<<20 for 1 cycle, then 0 -> next cycle S=20, valid=1; following cycle valid=0, S=20 held.
REQ-032 Bench SHALL cover: out_req=(1<<5)|(1<<21) -> next cycle S=5, valid=1, conflict=1, sticky=1, count=1; then out_req=1<<24 -> S=24, conflict=0, sticky=1.
REQ-033 Bench SHALL cover: 300 consecutive conflict cycles -> count=255 with no wrap; err_clr with out_req=1<<3 -> count=0, sticky=0, S=3.
REQ-034 Bench SHALL cover: err_clr with out_req=(1<<0)|(1<<1) on the same edge -> sticky=1, count=1, S=0.
REQ-035 Bench SHALL cover: clear asserted while out_req=1<<16 is held -> S=0, valid=0; after clear drops, next cycle S=16, valid=1.
